// File: rtl/axi4_stream_packet_sink.sv
// AXI4-Stream packet sink: buffers beats in a FIFO and builds one descriptor
// (ID/DEST/USER, byte and beat counts, error flag) per received packet.
module axi4_stream_packet_sink #(
    parameter int N     = 1,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1,
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             TVALID,
    output logic             TREADY,
    input  logic [8*N-1:0]   TDATA,
    input  logic [N-1:0]     TSTRB,
    input  logic [N-1:0]     TKEEP,
    input  logic             TLAST,
    input  logic [I-1:0]     TID,
    input  logic [D-1:0]     TDEST,
    input  logic [U-1:0]     TUSER,
    output logic             RD_VALID,
    input  logic             RD_EN,
    output logic [8*N-1:0]   RD_DATA,
    output logic [N-1:0]     RD_KEEP,
    output logic             RD_LAST,
    output logic             PKT_VALID,
    input  logic             PKT_ACK,
    output logic [I-1:0]     PKT_ID,
    output logic [D-1:0]     PKT_DEST,
    output logic [U-1:0]     PKT_USER,
    output logic [LEN_W-1:0] PKT_BYTES,
    output logic [LEN_W-1:0] PKT_BEATS,
    output logic             PKT_ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = 9 * N + 1;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    function automatic logic [LEN_W-1:0] popcnt(input logic [N-1:0] k);
        logic [LEN_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + LEN_W'(k[i]);
        return c;
    endfunction

    // Returns {saturated, sum}; the sum clamps at all-ones.
    function automatic logic [LEN_W:0] sat_add(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[LEN_W]) s = {1'b1, {LEN_W{1'b1}}};
        return s;
    endfunction

    logic [BW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level;
    logic             push, pop, full;
    logic [BW-1:0]    head;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beats_q, beats_d, bytes_q, bytes_d;
    logic             err_q, err_d;
    logic [I-1:0]     id_q, id_d;
    logic [D-1:0]     dest_q, dest_d;
    logic [LEN_W:0]   beats_sum, bytes_sum;
    logic [LEN_W-1:0] keep_cnt;
    logic             beat_err;

    assign full     = (level == FULL_LVL);
    assign RD_VALID = (level != '0);
    assign TREADY   = !full && !(TVALID && TLAST && PKT_VALID && !PKT_ACK);
    assign push     = TVALID && TREADY;
    assign pop      = RD_EN && RD_VALID;
    assign head     = mem[rd_ptr];
    assign {RD_DATA, RD_KEEP, RD_LAST} = RD_VALID ? head : '0;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= {TDATA, TKEEP, TLAST};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Candidate packet state for the beat currently offered on the stream.
    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        bytes_d   = bytes_q;
        err_d     = err_q;
        id_d      = id_q;
        dest_d    = dest_q;
        keep_cnt  = popcnt(TKEEP);
        beat_err  = (|(TSTRB & ~TKEEP)) || (TKEEP == '0);
        beats_sum = sat_add(beats_q, LEN_W'(1));
        bytes_sum = sat_add(bytes_q, keep_cnt);
        if (state_q == IDLE) begin
            beats_d = LEN_W'(1);
            bytes_d = keep_cnt;
            err_d   = beat_err;
            id_d    = TID;
            dest_d  = TDEST;
        end else begin
            beats_d = beats_sum[LEN_W-1:0];
            bytes_d = bytes_sum[LEN_W-1:0];
            err_d   = err_q || beat_err || beats_sum[LEN_W] || bytes_sum[LEN_W]
                      || (TID != id_q) || (TDEST != dest_q);
        end
        if (push) state_d = TLAST ? IDLE : RECV;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beats_q <= '0;
            bytes_q <= '0;
            err_q   <= 1'b0;
            id_q    <= '0;
            dest_q  <= '0;
        end else if (push) begin
            beats_q <= beats_d;
            bytes_q <= bytes_d;
            err_q   <= err_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
        end
    end

    // A TLAST beat can only be accepted when the old descriptor is free or being acked.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            PKT_VALID <= 1'b0;
            PKT_ID    <= '0;
            PKT_DEST  <= '0;
            PKT_USER  <= '0;
            PKT_BYTES <= '0;
            PKT_BEATS <= '0;
            PKT_ERR   <= 1'b0;
        end else if (push && TLAST) begin
            PKT_VALID <= 1'b1;
            PKT_ID    <= id_d;
            PKT_DEST  <= dest_d;
            PKT_USER  <= TUSER;
            PKT_BYTES <= bytes_d;
            PKT_BEATS <= beats_d;
            PKT_ERR   <= err_d;
        end else if (PKT_ACK) begin
            PKT_VALID <= 1'b0;
        end
    end

endmodule
